// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and types for the 16-way round-robin arbiter.
//   N_REQ : number of requesters
//   SEL_W : width of a requester index / mux select
//   arb_state_t : occupancy of the one-entry output register
package arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_32bit_16x1.sv
// mux_32bit_16x1: 16:1 word multiplexer over a flat bus.
// Ports:
//   data_in in  16*W  slice i = data_in[i*W +: W]
//   sel     in  4     slice select
//   data_out out W    selected slice
module mux_32bit_16x1
    import arb_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [N_REQ*W-1:0] data_in,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       data_out
);

    always_comb begin
        data_out = data_in[sel*W +: W];
    end

endmodule

// File: rtl/rr_pick_16.sv
// rr_pick_16: combinational round-robin priority picker.
// Ports:
//   req  in  16  request vector
//   ptr  in  4   highest-priority index
//   pick out 4   first set bit of req scanning ptr, ptr+1, ... (mod 16)
//   any  out 1   at least one request is set
module rr_pick_16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    // The 4-bit add wraps modulo 16 on its own.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: round-robin arbiter sharing one 16:1 mux between 16 requesters,
// capturing the granted word into a one-entry valid/ready output register.
// Ports:
//   clk          in  1     clock, rising edge
//   rst          in  1     synchronous active-high reset
//   req_i        in  16    per-requester request
//   data_i       in  16*W  flat data bus, slice i = data_i[i*W +: W]
//   gnt_o        out 16    one-hot grant, combinational, high in capture cycle
//   out_valid_o  out 1     output register holds a word
//   out_ready_i  in  1     downstream accepts the word this cycle
//   out_data_o   out W     captured word
//   out_src_o    out 4     index of the requester that produced out_data_o
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] data_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [W-1:0]       out_data_o,
    output logic [SEL_W-1:0]   out_src_o
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             capture;
    logic [W-1:0]     mux_out;

    rr_pick_16 u_pick (
        .req  (req_i),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    mux_32bit_16x1 #(
        .W (W)
    ) u_mux (
        .data_in  (data_i),
        .sel      (pick),
        .data_out (mux_out)
    );

    // A new word may enter whenever the register is empty or is being drained.
    always_comb begin
        capture = any && ((state == EMPTY) || out_ready_i);
    end

    always_comb begin
        gnt_o = '0;
        if (capture && !rst) begin
            gnt_o = N_REQ'(1) << pick;
        end
    end

    always_comb begin
        out_valid_o = (state == FULL);
    end

    // A capture always leaves the register FULL; a drain without capture empties it.
    // FULL with out_ready_i low has capture low, so everything holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            ptr        <= '0;
            out_data_o <= '0;
            out_src_o  <= '0;
        end else if (capture) begin
            state      <= FULL;
            ptr        <= pick + SEL_W'(1);
            out_data_o <= mux_out;
            out_src_o  <= pick;
        end else if (out_ready_i) begin
            state      <= EMPTY;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic [15:0]   req_i;
    logic [16*W-1:0] data_i;
    logic [15:0]   gnt_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  out_data_o;
    logic [3:0]    out_src_o;

    logic [W-1:0]  data_arr [16];

    int tests;
    int fails;

    // Reference model state
    bit            m_valid;
    logic [W-1:0]  m_data;
    int            m_src;
    int            m_ptr;

    rr_arbiter_16 #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        data_i = '0;
        for (int i = 0; i < 16; i++) begin
            data_i[i*W +: W] = data_arr[i];
        end
    end

    // First requesting index walking ptr, ptr+1, ... modulo 16; -1 if none.
    function automatic int model_pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    function automatic bit model_capture();
        return (req_i != 16'h0) && (!m_valid || out_ready_i);
    endfunction

    function automatic logic [15:0] model_gnt();
        logic [15:0] g;
        g = 16'h0;
        if (!rst && model_capture()) g[model_pick(req_i, m_ptr)] = 1'b1;
        return g;
    endfunction

    // Advance one clock: update the model from pre-edge inputs, return at the next negedge.
    task automatic tick();
        bit cap;
        int p;
        cap = model_capture();
        p   = model_pick(req_i, m_ptr);
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
        end else if (cap) begin
            m_valid = 1;
            m_data  = data_arr[p];
            m_src   = p;
            m_ptr   = (p + 1) % 16;
        end else if (out_ready_i) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_i = 16'hFFFF;
        out_ready_i = 1'b1;
        #1;
        tests++;
        if (gnt_o !== 16'h0) begin
            fails++;
            $display("FAIL reset_gnt: got %h want 0000", gnt_o);
        end
        tick();
        tick();
        rst = 1'b0;
        req_i = 16'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (gnt_o !== 16'h0) begin
                fails++;
                $display("FAIL idle_gnt: got %h want 0000", gnt_o);
            end
            tick();
            tests++;
            if (out_valid_o !== 1'b0 || out_src_o !== 4'd0 || out_data_o !== '0) begin
                fails++;
                $display("FAIL idle_out: valid %b src %0d data %h want 0/0/0",
                         out_valid_o, out_src_o, out_data_o);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) data_arr[i] = 32'hA000_0000 + i;
        req_i = 16'hFFFF;
        out_ready_i = 1'b1;
        for (int c = 0; c < 17; c++) begin
            #1;
            tests++;
            if (gnt_o !== (16'h1 << (c % 16))) begin
                fails++;
                $display("FAIL sweep_gnt[%0d]: got %h want %h", c, gnt_o, 16'h1 << (c % 16));
            end
            tick();
            tests++;
            if (out_valid_o !== 1'b1 || out_data_o !== 32'hA000_0000 + (c % 16)
                || out_src_o !== 4'(c % 16)) begin
                fails++;
                $display("FAIL sweep_out[%0d]: valid %b data %h src %0d want 1/%h/%0d", c,
                         out_valid_o, out_data_o, out_src_o, 32'hA000_0000 + (c % 16), c % 16);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [4];
        want[0] = 16'h4000;
        want[1] = 16'h8000;
        want[2] = 16'h0001;
        want[3] = 16'h8000;
        out_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_i = (c == 0) ? 16'h4000 : 16'h8001;
            #1;
            tests++;
            if (gnt_o !== want[c]) begin
                fails++;
                $display("FAIL wrap_gnt[%0d]: got %h want %h", c, gnt_o, want[c]);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        req_i = 16'h0008;
        out_ready_i = 1'b1;
        tick();
        tests++;
        if (out_src_o !== 4'd3 || out_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL hold_setup: src %0d valid %b want 3/1", out_src_o, out_valid_o);
        end
        req_i = 16'h0010;
        out_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if (gnt_o !== 16'h0) begin
                fails++;
                $display("FAIL hold_gnt[%0d]: got %h want 0000", c, gnt_o);
            end
            tick();
            tests++;
            if (out_valid_o !== 1'b1 || out_src_o !== 4'd3 || out_data_o !== data_arr[3]) begin
                fails++;
                $display("FAIL hold_out[%0d]: valid %b src %0d data %h want 1/3/%h", c,
                         out_valid_o, out_src_o, out_data_o, data_arr[3]);
            end
        end
        out_ready_i = 1'b1;
        #1;
        tests++;
        if (gnt_o !== 16'h0010) begin
            fails++;
            $display("FAIL hold_release_gnt: got %h want 0010", gnt_o);
        end
        tick();
        tests++;
        if (out_src_o !== 4'd4 || out_data_o !== data_arr[4]) begin
            fails++;
            $display("FAIL hold_release_out: src %0d data %h want 4/%h",
                     out_src_o, out_data_o, data_arr[4]);
        end
    endtask

    task automatic test_single();
        req_i = 16'h0080;
        out_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            tests++;
            if (gnt_o !== 16'h0080) begin
                fails++;
                $display("FAIL single_gnt[%0d]: got %h want 0080", c, gnt_o);
            end
            tick();
            tests++;
            if (out_valid_o !== 1'b1 || out_src_o !== 4'd7) begin
                fails++;
                $display("FAIL single_out[%0d]: valid %b src %0d want 1/7", c,
                         out_valid_o, out_src_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_i = 16'h00F0;
        out_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (gnt_o !== 16'h0) begin
            fails++;
            $display("FAIL midrst_gnt: got %h want 0000", gnt_o);
        end
        tick();
        rst = 1'b0;
        tests++;
        if (out_valid_o !== 1'b0 || out_src_o !== 4'd0 || out_data_o !== '0) begin
            fails++;
            $display("FAIL midrst_out: valid %b src %0d data %h want 0/0/0",
                     out_valid_o, out_src_o, out_data_o);
        end
        #1;
        tests++;
        if (gnt_o !== 16'h0010) begin
            fails++;
            $display("FAIL midrst_regrant: got %h want 0010", gnt_o);
        end
        tick();
        tests++;
        if (out_src_o !== 4'd4 || out_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL midrst_src: src %0d valid %b want 4/1", out_src_o, out_valid_o);
        end
    endtask

    task automatic test_random();
        logic [15:0] eg;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 16; i++) data_arr[i] = $urandom;
            case ($urandom_range(0, 3))
                0:       req_i = 16'h0;
                1:       req_i = 16'h1 << $urandom_range(0, 15);
                default: req_i = 16'($urandom);
            endcase
            out_ready_i = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            #1;
            eg = model_gnt();
            tests++;
            if (gnt_o !== eg) begin
                fails++;
                $display("FAIL rand_gnt[%0d]: got %h want %h", c, gnt_o, eg);
            end
            tick();
            tests++;
            if (out_valid_o !== m_valid || (m_valid
                && (out_data_o !== m_data || out_src_o !== 4'(m_src)))) begin
                fails++;
                $display("FAIL rand_out[%0d]: valid %b data %h src %0d want %b/%h/%0d", c,
                         out_valid_o, out_data_o, out_src_o, m_valid, m_data, m_src);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_valid = 0;
        m_data = '0;
        m_src = 0;
        m_ptr = 0;
        rst = 1'b1;
        req_i = 16'h0;
        out_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) data_arr[i] = '0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_wrap();
        test_hold();
        test_single();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
